paddle_ctrl: RTL and testbench

- Produces `right_paddle_pos` for the ball block.
- Consumes `ball_x_pos` and `ball_y_pos` from the ball block and reports paddle hits back.
- In manual mode it moves on debounced up/down buttons, with acceleration. In auto mode it tracks the ball.
- All motion is paced by an internal frame tick that it also exports.

---
 rtl/paddle_ctrl.sv | 128 ++++++++++++
 tb/tb_paddle_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl.sv
// Right-paddle controller: debounced manual buttons with acceleration, or ball tracking
// in auto mode. All motion and hit reporting are paced by a free-running frame tick.
module paddle_ctrl #(
  parameter int SCREEN_H   = 480,
  parameter int PAD_HALF   = 20,
  parameter int PAD_X      = 540,
  parameter int STEP_MIN   = 2,
  parameter int STEP_MAX   = 8,
  parameter int TICK_BITS  = 18,
  parameter int DEB_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       auto_mode,
  input  logic [9:0] ball_x_pos,
  input  logic [9:0] ball_y_pos,
  output logic [9:0] right_paddle_pos,
  output logic       frame_tick,
  output logic       hit
);
  typedef enum logic [1:0] {IDLE, UP, DOWN, TRACK} state_t;

  localparam int NUM_BTN = 2;
  localparam int DCW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SPW     = $clog2(STEP_MAX + 1);
  localparam logic signed [11:0] POS_LO = 12'(PAD_HALF);
  localparam logic signed [11:0] POS_HI = 12'(SCREEN_H - 1 - PAD_HALF);
  localparam logic signed [11:0] SMAX   = 12'(STEP_MAX);
  localparam logic signed [11:0] HALF   = 12'(PAD_HALF);

  state_t                       state, state_nxt;
  logic [TICK_BITS-1:0]         tick_cnt;
  logic                         tick;
  logic [NUM_BTN-1:0]           raw_btn, deb_btn;
  logic [NUM_BTN-1:0][1:0]      sync;
  logic [NUM_BTN-1:0][DCW-1:0]  deb_cnt;
  logic [9:0]                   pos, pos_nxt;
  logic [SPW-1:0]               speed, speed_nxt, step;
  logic signed [11:0]           pos_s, ball_s, diff, mag, step_s, delta, new_pos;
  logic                         hit_nxt;

  assign tick             = &tick_cnt;
  assign raw_btn          = {btn_down, btn_up};
  assign right_paddle_pos = pos;

  // Per-button 2-flop synchroniser then a stability counter; a change is accepted
  // only after DEB_CYCLES consecutive samples disagree with the debounced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      deb_cnt <= '0;
      deb_btn <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        sync[i] <= {sync[i][0], raw_btn[i]};
        if (sync[i][1] == deb_btn[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
          deb_btn[i] <= ~deb_btn[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     state <= IDLE;
    else if (tick) state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (auto_mode)             state_nxt = TRACK;
    else if (deb_btn == 2'b01) state_nxt = UP;
    else if (deb_btn == 2'b10) state_nxt = DOWN;
  end

  // The move on a tick uses the state decided on that tick; entering a state starts at STEP_MIN.
  always_comb begin
    pos_s     = {2'b00, pos};
    ball_s    = {2'b00, ball_y_pos};
    diff      = ball_s - pos_s;
    mag       = diff[11] ? -diff : diff;
    step      = (state_nxt == state) ? speed : SPW'(STEP_MIN);
    step_s    = 12'(step);
    speed_nxt = SPW'(STEP_MIN);
    delta     = '0;
    case (state_nxt)
      UP: begin
        delta     = -step_s;
        speed_nxt = (step >= SPW'(STEP_MAX)) ? SPW'(STEP_MAX) : step + SPW'(1);
      end
      DOWN: begin
        delta     = step_s;
        speed_nxt = (step >= SPW'(STEP_MAX)) ? SPW'(STEP_MAX) : step + SPW'(1);
      end
      TRACK:   delta = (mag > SMAX) ? (diff[11] ? -SMAX : SMAX) : diff;
      default: delta = '0;
    endcase
    new_pos = pos_s + delta;
    if (new_pos < POS_LO)      new_pos = POS_LO;
    else if (new_pos > POS_HI) new_pos = POS_HI;
    pos_nxt = 10'(new_pos);
    hit_nxt = (ball_x_pos >= 10'(PAD_X)) && (mag <= HALF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt   <= '0;
      pos        <= 10'(SCREEN_H / 2);
      speed      <= SPW'(STEP_MIN);
      frame_tick <= 1'b0;
      hit        <= 1'b0;
    end else begin
      tick_cnt   <= tick_cnt + TICK_BITS'(1);
      frame_tick <= tick;
      hit        <= tick & hit_nxt;
      if (tick) begin
        pos   <= pos_nxt;
        speed <= speed_nxt;
      end
    end
  end
endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed scenarios plus random ticks against an integer
// model of the paddle rules (TICK_BITS=4, DEB_CYCLES=3).
module tb_paddle_ctrl;
  logic       clk = 1'b0, reset = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, auto_mode = 1'b0;
  logic [9:0] ball_x_pos = '0, ball_y_pos = 10'd240;
  logic [9:0] right_paddle_pos;
  logic       frame_tick, hit;

  int vectors = 0, errors = 0;
  int m_pos = 240, m_mode = 0, m_speed = 2;  // mode: 0 idle, 1 up, 2 down, 3 track
  int exp_pos;
  logic exp_hit;

  paddle_ctrl #(.TICK_BITS(4), .DEB_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .auto_mode(auto_mode), .ball_x_pos(ball_x_pos), .ball_y_pos(ball_y_pos),
    .right_paddle_pos(right_paddle_pos), .frame_tick(frame_tick), .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int want, step, d;
    want = auto_mode ? 3 : (btn_up && !btn_down) ? 1 : (btn_down && !btn_up) ? 2 : 0;
    d = int'(ball_y_pos) - m_pos;
    exp_hit = (int'(ball_x_pos) >= 540) && (d <= 20) && (d >= -20);
    step = (want == m_mode) ? m_speed : 2;
    exp_pos = m_pos;
    m_speed = 2;
    if (want == 1) begin
      exp_pos = m_pos - step;
      m_speed = (step < 8) ? step + 1 : 8;
    end else if (want == 2) begin
      exp_pos = m_pos + step;
      m_speed = (step < 8) ? step + 1 : 8;
    end else if (want == 3) begin
      exp_pos = m_pos + ((d > 8) ? 8 : (d < -8) ? -8 : d);
    end
    if (exp_pos < 20)  exp_pos = 20;
    if (exp_pos > 459) exp_pos = 459;
    m_pos  = exp_pos;
    m_mode = want;
  endtask

  task automatic model_reset();
    m_pos = 240; m_mode = 0; m_speed = 2;
  endtask

  // Waits for the next frame_tick (bounded), then checks pos and hit against the model.
  task automatic next_tick(input string nm, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (frame_tick !== 1'b1) begin
        vectors++;
        if (hit !== 1'b0) begin
          errors++;
          $display("FAIL %s hit_off_tick: got %b expected 0", nm, hit);
        end
      end
    end while (frame_tick !== 1'b1 && cyc < 40);
    vectors++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL %s tick_timeout: no frame_tick in %0d cycles, expected within 16", nm, cyc);
    end
    model_step();
    vectors++;
    if (right_paddle_pos !== 10'(exp_pos)) begin
      errors++;
      $display("FAIL %s pos: got %0d expected %0d", nm, right_paddle_pos, exp_pos);
    end
    vectors++;
    if (hit !== exp_hit) begin
      errors++;
      $display("FAIL %s hit: got %b expected %b", nm, hit, exp_hit);
    end
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    #1;
    vectors++;
    if (right_paddle_pos !== 10'd240 || frame_tick !== 1'b0 || hit !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_state: got pos=%0d tick=%b hit=%b expected pos=240 tick=0 hit=0",
               nm, right_paddle_pos, frame_tick, hit);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive_to(input int target);
    int c;
    auto_mode = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    ball_x_pos = '0; ball_y_pos = 10'(target);
    for (int i = 0; i < 80 && m_pos != target; i++) next_tick("drive", c);
    vectors++;
    if (right_paddle_pos !== 10'(target)) begin
      errors++;
      $display("FAIL drive_to: got %0d expected %0d", right_paddle_pos, target);
    end
  endtask

  task automatic check_pos(input string nm, input int want);
    vectors++;
    if (right_paddle_pos !== 10'(want)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, right_paddle_pos, want);
    end
  endtask

  task automatic test_reset();
    int c;
    btn_up = 1'b1;
    repeat (3) next_tick("rst_pre", c);
    btn_up = 1'b0;
    do_reset("rst_mid");
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      vectors++;
      if (frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL rst_early_tick: got 1 at cycle %0d expected 0", i + 1);
      end
    end
    next_tick("rst_first", c);
    vectors++;
    if (c != 1) begin
      errors++;
      $display("FAIL rst_first_period: got pulse at %0d expected 16", 15 + c);
    end
    next_tick("rst_period", c);
    vectors++;
    if (c != 16) begin
      errors++;
      $display("FAIL rst_period: got %0d expected 16", c);
    end
  endtask

  task automatic test_up_accel();
    int c;
    int seq[5] = '{238, 235, 231, 226, 220};
    repeat (4) @(negedge clk);
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    btn_up = 1'b0;
    next_tick("glitch_idle", c);
    check_pos("glitch_idle_pos", 240);
    btn_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_tick("up_accel", c);
      check_pos("up_accel_seq", seq[i]);
    end
    repeat (4) @(negedge clk);
    btn_up = 1'b0;
    repeat (2) @(negedge clk);
    btn_up = 1'b1;
    for (int i = 0; i < 7; i++) next_tick("up_more", c);
    check_pos("up_after_glitch", 165);
    next_tick("up_pinned", c);
    check_pos("up_speed_pinned", 157);
    btn_up = 1'b0;
  endtask

  task automatic test_down_clamp();
    int c;
    drive_to(455);
    auto_mode = 1'b0; btn_down = 1'b1;
    next_tick("down", c); check_pos("down_first", 457);
    next_tick("down", c); check_pos("down_clamp", 459);
    next_tick("down", c); check_pos("down_hold", 459);
    btn_up = 1'b1;
    next_tick("both", c); check_pos("both_idle", 459);
    btn_down = 1'b0;
    next_tick("restart", c); check_pos("restart_speed2", 457);
    btn_up = 1'b0;
  endtask

  task automatic test_track();
    int c;
    drive_to(240);
    ball_y_pos = 10'd100;
    next_tick("track", c); check_pos("track_first", 232);
    repeat (16) next_tick("track", c);
    check_pos("track_near", 104);
    next_tick("track", c); check_pos("track_remainder", 100);
    next_tick("track", c); check_pos("track_settled", 100);
    ball_y_pos = 10'd5;
    repeat (10) next_tick("track_lo", c);
    check_pos("track_lo", 20);
    next_tick("track_lo", c); check_pos("track_lo_clamp", 20);
  endtask

  task automatic test_hit();
    int c;
    drive_to(240);
    auto_mode = 1'b0; ball_x_pos = 10'd545; ball_y_pos = 10'd260;
    next_tick("hit_edge", c);
    vectors++;
    if (hit !== 1'b1 || frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL hit_edge: got hit=%b tick=%b expected 1 1", hit, frame_tick);
    end
    @(negedge clk);
    vectors++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_one_cycle: got %b expected 0", hit);
    end
    ball_y_pos = 10'd261;
    next_tick("hit_y_out", c);
    vectors++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_y_out: got %b expected 0", hit);
    end
    ball_x_pos = 10'd539; ball_y_pos = 10'd260;
    next_tick("hit_x_out", c);
    vectors++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_x_out: got %b expected 0", hit);
    end
    ball_x_pos = 10'd545; ball_y_pos = 10'd220;
    next_tick("hit_low_edge", c);
    ball_x_pos = '0;
  endtask

  task automatic test_reset_move();
    int c;
    btn_up = 1'b1;
    repeat (4) next_tick("rm_up", c);
    check_pos("rm_before", 226);
    repeat (3) @(negedge clk);
    do_reset("rm_mid_move");
    next_tick("rm_after", c);
    check_pos("rm_speed_restart", 238);
    btn_up = 1'b0;
  endtask

  task automatic test_random();
    int c, y;
    for (int i = 0; i < 60; i++) begin
      auto_mode = ($urandom_range(0, 3) == 0);
      btn_up    = 1'($urandom_range(0, 1));
      btn_down  = 1'($urandom_range(0, 1));
      ball_x_pos = 10'($urandom_range(520, 560));
      if ($urandom_range(0, 1) == 1) y = m_pos + int'($urandom_range(0, 60)) - 30;
      else y = int'($urandom_range(0, 479));
      if (y < 0) y = 0;
      if (y > 479) y = 479;
      ball_y_pos = 10'(y);
      next_tick("random", c);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_up_accel();
    test_down_clamp();
    test_track();
    test_hit();
    test_reset_move();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
